tri_read_fifo: RTL and testbench

- Circular-buffer FIFO with one write port and a read port that pops 0 to 3 entries per cycle.
- Complements the multi-write PE FIFO. A single producer (e.g. the PE result path) pushes one word per cycle.
- A wide consumer (e.g. the 3-operand instruction issue stage) drains up to three words per cycle in FIFO order.
- Data outputs are registered.

---
 rtl/tri_fifo_pkg.sv | 27 ++
 rtl/fifo_ptr_wrap.sv | 32 +++
 rtl/tri_read_fifo.sv | 150 +++++++++++++++
 tb/tb_tri_read_fifo.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/tri_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tri_fifo_pkg
// Brief    : Shared read-count encodings, valid-mask table and pointer sizing
//            for the tri-read FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package tri_fifo_pkg;

    localparam logic [1:0] RD_NONE  = 2'd0;
    localparam logic [1:0] RD_ONE   = 2'd1;
    localparam logic [1:0] RD_TWO   = 2'd2;
    localparam logic [1:0] RD_THREE = 2'd3;

    // Indexed by read count: 000, 001, 011, 111.
    localparam logic [11:0] VALID_MASK_TABLE = {3'b111, 3'b011, 3'b001, 3'b000};

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic logic [2:0] valid_mask(input logic [1:0] n);
        return VALID_MASK_TABLE[3*n +: 3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_wrap.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr_wrap
// Brief    : Combinational modular adder, (ptr + inc) mod DEPTH, inc in 0..3.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr_wrap
    import tri_fifo_pkg::*;
#(
    parameter int DEPTH = 24,
    parameter int PTR_W = 5
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [1:0]       inc,
    output logic [PTR_W-1:0] sum
);

    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0] w_raw;
    logic [PTR_W:0] w_wrapped;

    // ptr <= DEPTH-1 and inc <= 3 keep the raw sum below 2*DEPTH, so one
    // conditional subtract is a full modulo for any DEPTH >= 3.
    always_comb begin
        w_raw     = {1'b0, ptr} + (PTR_W+1)'(inc);
        w_wrapped = (w_raw >= c_depth) ? (w_raw - c_depth) : w_raw;
        sum       = w_wrapped[PTR_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/tri_read_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tri_read_fifo
// Brief    : Single-write FIFO whose read port pops 0..3 entries per cycle
//            with registered outputs. Define TRI_READ_FIFO_ERR_EN to add
//            sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module tri_read_fifo
    import tri_fifo_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       write,
    input  logic [1:0]                 read_cnt,
    output logic [WIDTH-1:0]           data_out1,
    output logic [WIDTH-1:0]           data_out2,
    output logic [WIDTH-1:0]           data_out3,
    output logic [2:0]                 out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       fifo_full,
    output logic                       fifo_empty
`ifdef TRI_READ_FIFO_ERR_EN
   ,output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    generate
        if (DEPTH < 3) begin : g_depth_check
            $error("tri_read_fifo: DEPTH must be >= 3");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_data_out1;
    logic [WIDTH-1:0] r_data_out2;
    logic [WIDTH-1:0] r_data_out3;
    logic [2:0]       r_out_valid;

    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_p1;
    logic [PTR_W-1:0] w_rd_ptr_p2;
    logic             w_wr_accept;
    logic             w_rd_accept;
    logic [CNT_W-1:0] w_count_next;

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_wrap (
        .ptr(r_wr_ptr), .inc(RD_ONE), .sum(w_wr_ptr_next)
    );
    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_wrap (
        .ptr(r_rd_ptr), .inc(read_cnt), .sum(w_rd_ptr_next)
    );
    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_p1_wrap (
        .ptr(r_rd_ptr), .inc(RD_ONE), .sum(w_rd_ptr_p1)
    );
    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_p2_wrap (
        .ptr(r_rd_ptr), .inc(RD_TWO), .sum(w_rd_ptr_p2)
    );

    // Both acceptances look only at the pre-edge count: a same-cycle pop
    // never frees room for the write, and a fresh write is never popped.
    always_comb begin
        w_wr_accept  = write && !fifo_full;
        w_rd_accept  = (read_cnt != RD_NONE) && (CNT_W'(read_cnt) <= r_count);
        w_count_next = r_count + CNT_W'(w_wr_accept)
                       - (w_rd_accept ? CNT_W'(read_cnt) : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_accept) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 3'b000;
            r_data_out1 <= '0;
            r_data_out2 <= '0;
            r_data_out3 <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_wr_accept) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_rd_accept) begin
                r_rd_ptr    <= w_rd_ptr_next;
                r_out_valid <= valid_mask(read_cnt);
                if (read_cnt >= RD_ONE) begin
                    r_data_out1 <= r_mem[r_rd_ptr];
                end
                if (read_cnt >= RD_TWO) begin
                    r_data_out2 <= r_mem[w_rd_ptr_p1];
                end
                if (read_cnt == RD_THREE) begin
                    r_data_out3 <= r_mem[w_rd_ptr_p2];
                end
            end else begin
                r_out_valid <= 3'b000;
            end
        end
    end

`ifdef TRI_READ_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write && fifo_full) begin
                r_overflow <= 1'b1;
            end
            if ((read_cnt != RD_NONE) && (CNT_W'(read_cnt) > r_count)) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign data_out1  = r_data_out1;
    assign data_out2  = r_data_out2;
    assign data_out3  = r_data_out3;
    assign out_valid  = r_out_valid;
    assign count      = r_count;
    assign fifo_full  = (r_count == CNT_W'(DEPTH));
    assign fifo_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_tri_read_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_read_fifo
// Brief    : Directed plus random bench for tri_read_fifo (DEPTH=5) against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tri_read_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 5;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             write;
    logic [1:0]       read_cnt;
    logic [WIDTH-1:0] data_out1, data_out2, data_out3;
    logic [2:0]       out_valid;
    logic [CNT_W-1:0] count;
    logic             fifo_full, fifo_empty;
`ifdef TRI_READ_FIFO_ERR_EN
    logic             overflow, underflow;
`endif

    always #5 clk = ~clk;

    tri_read_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .write(write),
        .read_cnt(read_cnt), .data_out1(data_out1), .data_out2(data_out2),
        .data_out3(data_out3), .out_valid(out_valid), .count(count),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
`ifdef TRI_READ_FIFO_ERR_EN
       ,.overflow(overflow), .underflow(underflow)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the FIFO is just a queue of words.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_d[3];
    logic [2:0]       m_valid;
    logic             m_ovf, m_udf;

    task automatic compare_all();
        chk("count", 64'(count), 64'(q.size()));
        chk("full",  64'(fifo_full), 64'(q.size() == DEPTH));
        chk("empty", 64'(fifo_empty), 64'(q.size() == 0));
        chk("valid", 64'(out_valid), 64'(m_valid));
        chk("dout1", 64'(data_out1), 64'(m_d[0]));
        chk("dout2", 64'(data_out2), 64'(m_d[1]));
        chk("dout3", 64'(data_out3), 64'(m_d[2]));
`ifdef TRI_READ_FIFO_ERR_EN
        chk("ovf", 64'(overflow), 64'(m_ovf));
        chk("udf", 64'(underflow), 64'(m_udf));
`endif
    endtask

    task automatic step(input logic w, input logic [WIDTH-1:0] d,
                        input logic [1:0] n, input logic r);
        int sz;
        rst = r; write = w; data_in = d; read_cnt = n;
        @(posedge clk);
        sz = q.size();
        if (r) begin
            q.delete();
            m_valid = 3'b000;
            for (int i = 0; i < 3; i++) m_d[i] = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && sz == DEPTH) m_ovf = 1'b1;
            if (n != 0 && int'(n) > sz) m_udf = 1'b1;
            if (n != 0 && int'(n) <= sz) begin
                for (int i = 0; i < int'(n); i++) m_d[i] = q.pop_front();
                m_valid = 3'((1 << n) - 1);
            end else begin
                m_valid = 3'b000;
            end
            if (w && sz < DEPTH) q.push_back(d);
        end
        #1;
        compare_all();
    endtask

    initial begin
        m_valid = 3'b000;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        for (int i = 0; i < 3; i++) m_d[i] = '0;

        // Reset then idle, rejected read on empty
        step(1'b0, '0, 2'd0, 1'b1);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        step(1'b0, '0, 2'd0, 1'b0);
        step(1'b0, '0, 2'd1, 1'b0);
        chk("empty_rd_valid", 64'(out_valid), 64'd0);

        // A, B, C then pop three
        step(1'b1, 16'hA, 2'd0, 1'b0);
        step(1'b1, 16'hB, 2'd0, 1'b0);
        step(1'b1, 16'hC, 2'd0, 1'b0);
        step(1'b0, '0, 2'd3, 1'b0);
        chk("abc_d1", 64'(data_out1), 64'hA);
        chk("abc_d2", 64'(data_out2), 64'hB);
        chk("abc_d3", 64'(data_out3), 64'hC);
        chk("abc_valid", 64'(out_valid), 64'b111);
        chk("abc_count", 64'(count), 64'd0);

        // Fill, drop on full, wrap the pointers
        for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 2'd0, 1'b0);
        chk("fill_full", 64'(fifo_full), 64'd1);
        step(1'b1, 16'h6, 2'd0, 1'b0);
        chk("drop_count", 64'(count), 64'd5);
        step(1'b0, '0, 2'd2, 1'b0);
        step(1'b1, 16'h6, 2'd0, 1'b0);
        step(1'b1, 16'h7, 2'd0, 1'b0);
        step(1'b0, '0, 2'd3, 1'b0);
        chk("wrap3_d3", 64'(data_out3), 64'h5);
        step(1'b0, '0, 2'd2, 1'b0);
        chk("wrap2_d1", 64'(data_out1), 64'h6);
        chk("wrap2_d2", 64'(data_out2), 64'h7);

        // Oversized request is rejected whole
        step(1'b1, 16'h11, 2'd0, 1'b0);
        step(1'b1, 16'h12, 2'd0, 1'b0);
        step(1'b0, '0, 2'd3, 1'b0);
        chk("udf_count", 64'(count), 64'd2);
        chk("udf_valid", 64'(out_valid), 64'd0);
        step(1'b0, '0, 2'd2, 1'b0);
        chk("udf_next_d1", 64'(data_out1), 64'h11);

        // Simultaneous write and read
        for (int i = 0; i < 4; i++) step(1'b1, 16'(8'h20 + i), 2'd0, 1'b0);
        step(1'b1, 16'h30, 2'd2, 1'b0);
        chk("sim_count3", 64'(count), 64'd3);
        step(1'b1, 16'h31, 2'd0, 1'b0);
        step(1'b1, 16'h32, 2'd0, 1'b0);
        step(1'b1, 16'h33, 2'd1, 1'b0);
        chk("sim_full_count", 64'(count), 64'(DEPTH-1));

        // Reset mid-operation with count 4
        step(1'b1, 16'h44, 2'd3, 1'b1);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_empty", 64'(fifo_empty), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 55),
                 16'($urandom),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
